// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer and the control unit.
//   - 5-bit opcode constants, including the sequencer-internal second parts
//   - sequencer state encoding
//   - issue record (opcode, rsrc, rdst, bubble) presented to the control unit
package isa_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LDM   = 5'b10001;
  localparam logic [4:0] OP_CALL  = 5'b11000;
  localparam logic [4:0] OP_CALL2 = 5'b11001;
  localparam logic [4:0] OP_RET   = 5'b11010;
  localparam logic [4:0] OP_RET2  = 5'b11011;
  localparam logic [4:0] OP_RTI   = 5'b11100;
  localparam logic [4:0] OP_RTI2  = 5'b11101;
  localparam logic [4:0] OP_INT1  = 5'b11110;
  localparam logic [4:0] OP_INT2  = 5'b11111;

  typedef enum logic [2:0] {
    ST_NORMAL   = 3'd0,
    ST_LDM_WAIT = 3'd1,
    ST_CALL2    = 3'd2,
    ST_RET2     = 3'd3,
    ST_RTI2     = 3'd4,
    ST_INT1     = 3'd5,
    ST_INT2     = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rsrc;
    logic [2:0] rdst;
    logic       bubble;
  } issue_t;

  localparam issue_t ISSUE_BUBBLE = '{op: OP_NOP, rsrc: 3'd0, rdst: 3'd0, bubble: 1'b1};

  // Opcodes that only the sequencer may generate; a fetched copy is squashed.
  function automatic logic is_internal_op(input logic [4:0] op);
    return (op == OP_CALL2) || (op == OP_RET2) || (op == OP_RTI2) ||
           (op == OP_INT1)  || (op == OP_INT2);
  endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: turns fetched words into control-unit issues, expanding
// CALL/RET/RTI into two parts, LDM into opcode + immediate word, and injecting
// the two-part interrupt entry sequence.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// NORMAL    | decode and issue the fetched word, or take a pending interrupt
// LDM_WAIT  | LDM seen, waiting for the immediate word
// CALL2     | 11000 on the outputs, 11001 goes out next
// RET2      | 11010 on the outputs, 11011 goes out next
// RTI2      | 11100 on the outputs, 11101 goes out next
// INT1      | 11110 on the outputs, 11111 goes out next (flush cannot stop it)
// INT2      | 11111 on the outputs, fetch word still held, bubble next
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   instr_in[15:0]    fetched word: opcode[15:11], rsrc[10:8], rdst[7:5]
//   instr_valid       instr_in valid this cycle
//   stall, flush      hazard hold / branch squash
//   intr              interrupt request pulse
//   opCode, rsrc,     registered issue to the control unit
//   rdst, imm
//   makeMeBubble      issued slot is a bubble
//   pc_hold           fetch must re-present the same word
//   in_isr            interrupt service in progress
module instruction_sequencer
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        intr,
  output logic [4:0]  opCode,
  output logic [2:0]  rsrc,
  output logic [2:0]  rdst,
  output logic [15:0] imm,
  output logic        makeMeBubble,
  output logic        pc_hold,
  output logic        in_isr
);

  seq_state_e  state_q;
  issue_t      issue_q;
  logic [15:0] imm_q;
  logic        pc_hold_q;
  logic [2:0]  ldm_rsrc_q;
  logic [2:0]  ldm_rdst_q;
  logic        pending_q, pending_d;
  logic        in_isr_q, in_isr_d;

  logic [4:0]  fetch_op;
  logic [2:0]  fetch_rsrc;
  logic [2:0]  fetch_rdst;
  logic        take_int;
  logic        rti2_issue;

  assign fetch_op   = instr_in[15:11];
  assign fetch_rsrc = instr_in[10:8];
  assign fetch_rdst = instr_in[7:5];

  assign take_int   = (state_q == ST_NORMAL) && !stall && !flush && !in_isr_q && pending_q;
  assign rti2_issue = (state_q == ST_RTI2) && !stall && !flush;

  // Sequencing FSM with registered issue outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_NORMAL;
      issue_q    <= ISSUE_BUBBLE;
      imm_q      <= 16'h0000;
      pc_hold_q  <= 1'b0;
      ldm_rsrc_q <= 3'd0;
      ldm_rdst_q <= 3'd0;
    end else if (flush) begin
      if (state_q == ST_INT1) begin
        // Interrupt entry is atomic: the second part survives a flush.
        issue_q.op <= OP_INT2;
        pc_hold_q  <= 1'b1;
        state_q    <= ST_INT2;
      end else begin
        issue_q   <= ISSUE_BUBBLE;
        pc_hold_q <= 1'b0;
        state_q   <= ST_NORMAL;
      end
    end else if (stall) begin
      pc_hold_q <= 1'b1;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (take_int) begin
            issue_q   <= '{op: OP_INT1, rsrc: 3'd0, rdst: 3'd0, bubble: 1'b0};
            pc_hold_q <= 1'b1;
            state_q   <= ST_INT1;
          end else if (!instr_valid) begin
            issue_q   <= ISSUE_BUBBLE;
            pc_hold_q <= 1'b0;
          end else begin
            case (fetch_op)
              OP_CALL, OP_RET, OP_RTI: begin
                issue_q   <= '{op: fetch_op, rsrc: fetch_rsrc, rdst: fetch_rdst, bubble: 1'b0};
                pc_hold_q <= 1'b1;
                if (fetch_op == OP_CALL)     state_q <= ST_CALL2;
                else if (fetch_op == OP_RET) state_q <= ST_RET2;
                else                         state_q <= ST_RTI2;
              end
              OP_LDM: begin
                issue_q    <= ISSUE_BUBBLE;
                pc_hold_q  <= 1'b0;
                ldm_rsrc_q <= fetch_rsrc;
                ldm_rdst_q <= fetch_rdst;
                state_q    <= ST_LDM_WAIT;
              end
              default: begin
                pc_hold_q <= 1'b0;
                if (is_internal_op(fetch_op))
                  issue_q <= ISSUE_BUBBLE;
                else
                  issue_q <= '{op: fetch_op, rsrc: fetch_rsrc, rdst: fetch_rdst, bubble: 1'b0};
              end
            endcase
          end
        end
        ST_LDM_WAIT: begin
          pc_hold_q <= 1'b0;
          if (instr_valid) begin
            imm_q   <= instr_in;
            issue_q <= '{op: OP_LDM, rsrc: ldm_rsrc_q, rdst: ldm_rdst_q, bubble: 1'b0};
            state_q <= ST_NORMAL;
          end else begin
            issue_q <= ISSUE_BUBBLE;
          end
        end
        // Second parts keep the first part's rsrc/rdst, still held in issue_q.
        ST_CALL2: begin
          issue_q.op <= OP_CALL2;
          pc_hold_q  <= 1'b0;
          state_q    <= ST_NORMAL;
        end
        ST_RET2: begin
          issue_q.op <= OP_RET2;
          pc_hold_q  <= 1'b0;
          state_q    <= ST_NORMAL;
        end
        ST_RTI2: begin
          issue_q.op <= OP_RTI2;
          pc_hold_q  <= 1'b0;
          state_q    <= ST_NORMAL;
        end
        ST_INT1: begin
          issue_q.op <= OP_INT2;
          pc_hold_q  <= 1'b1;
          state_q    <= ST_INT2;
        end
        ST_INT2: begin
          // The word presented during INT2 was held by pc_hold; it is consumed next.
          issue_q   <= ISSUE_BUBBLE;
          pc_hold_q <= 1'b0;
          state_q   <= ST_NORMAL;
        end
        default: begin
          issue_q   <= ISSUE_BUBBLE;
          pc_hold_q <= 1'b0;
          state_q   <= ST_NORMAL;
        end
      endcase
    end
  end

  // Interrupt pending / in-service tracking. Pending survives flush and stall;
  // a new pulse in the take cycle stays pending.
  always_comb begin
    pending_d = intr | (pending_q & ~take_int);
    in_isr_d  = in_isr_q;
    if (take_int)
      in_isr_d = 1'b1;
    else if (rti2_issue)
      in_isr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      in_isr_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      in_isr_q  <= in_isr_d;
    end
  end

  assign opCode       = issue_q.op;
  assign rsrc         = issue_q.rsrc;
  assign rdst         = issue_q.rdst;
  assign makeMeBubble = issue_q.bubble;
  assign imm          = imm_q;
  assign pc_hold      = pc_hold_q;
  assign in_isr       = in_isr_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model of
// the issue stream.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        intr = 1'b0;
  logic [4:0]  opCode;
  logic [2:0]  rsrc, rdst;
  logic [15:0] imm;
  logic        makeMeBubble, pc_hold, in_isr;

  instruction_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .intr(intr),
    .opCode(opCode), .rsrc(rsrc), .rdst(rdst), .imm(imm),
    .makeMeBubble(makeMeBubble), .pc_hold(pc_hold), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // ---------------- reference model ----------------
  // Upcoming slots the sequencer owes (second parts, INT2, trailing bubble).
  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rs;
    logic [2:0] rd;
    logic       bub;
    logic       pc;
    logic       atomic;
  } item_t;

  item_t       owed[$];
  logic [4:0]  e_op;
  logic [2:0]  e_rs, e_rd;
  logic        e_bub, e_pc, e_isr;
  logic [15:0] e_imm;
  logic        m_pend, m_ldm;
  logic [2:0]  m_rs, m_rd;

  function automatic item_t mk(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd,
                               input logic bub, input logic pc, input logic atomic);
    item_t t;
    t.op = op; t.rs = rs; t.rd = rd; t.bub = bub; t.pc = pc; t.atomic = atomic;
    return t;
  endfunction

  task automatic emit(input item_t t);
    e_op = t.op; e_rs = t.rs; e_rd = t.rd; e_bub = t.bub; e_pc = t.pc;
    if (t.op == 5'b11101) e_isr = 1'b0;
  endtask

  task automatic emit_bubble();
    emit(mk(5'b00000, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic model_step(input logic r, input logic [15:0] w, input logic v,
                            input logic s, input logic f, input logic it);
    logic       take;
    logic [4:0] op;
    take = 1'b0;
    op   = w[15:11];
    if (!r) begin
      emit_bubble();
      e_isr = 1'b0; e_imm = 16'h0000; m_pend = 1'b0; m_ldm = 1'b0;
      owed.delete();
    end else begin
      if (f) begin
        if (owed.size() > 0 && owed[0].atomic) emit(owed.pop_front());
        else begin owed.delete(); m_ldm = 1'b0; emit_bubble(); end
      end else if (s) begin
        e_pc = 1'b1;
      end else if (owed.size() > 0) begin
        emit(owed.pop_front());
      end else if (m_ldm) begin
        if (v) begin
          e_imm = w; m_ldm = 1'b0;
          emit(mk(5'b10001, m_rs, m_rd, 1'b0, 1'b0, 1'b0));
        end else emit_bubble();
      end else if (m_pend && !e_isr) begin
        take = 1'b1; e_isr = 1'b1;
        emit(mk(5'b11110, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0));
        owed.push_back(mk(5'b11111, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1));
        owed.push_back(mk(5'b00000, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
      end else if (!v) begin
        emit_bubble();
      end else if (op == 5'b11000 || op == 5'b11010 || op == 5'b11100) begin
        emit(mk(op, w[10:8], w[7:5], 1'b0, 1'b1, 1'b0));
        owed.push_back(mk(op + 5'd1, w[10:8], w[7:5], 1'b0, 1'b0, 1'b0));
      end else if (op == 5'b10001) begin
        emit_bubble(); m_ldm = 1'b1; m_rs = w[10:8]; m_rd = w[7:5];
      end else if (op == 5'b11001 || op == 5'b11011 || op == 5'b11101 ||
                   op == 5'b11110 || op == 5'b11111) begin
        emit_bubble();
      end else begin
        emit(mk(op, w[10:8], w[7:5], 1'b0, 1'b0, 1'b0));
      end
      m_pend = it | (m_pend & !take);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cycle %0d: observed %0h, expected %0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("opCode", {11'd0, opCode}, {11'd0, e_op});
    chk("makeMeBubble", {15'd0, makeMeBubble}, {15'd0, e_bub});
    chk("pc_hold", {15'd0, pc_hold}, {15'd0, e_pc});
    chk("in_isr", {15'd0, in_isr}, {15'd0, e_isr});
    chk("imm", imm, e_imm);
    // Register fields are defined only for real issued instructions.
    if (!e_bub && e_op != 5'b11110 && e_op != 5'b11111) begin
      chk("rdst", {13'd0, rdst}, {13'd0, e_rd});
      if (e_op != 5'b10001) chk("rsrc", {13'd0, rsrc}, {13'd0, e_rs});
    end
  endtask

  task automatic cyc(input logic r, input logic [15:0] w, input logic v,
                     input logic s, input logic f, input logic it);
    rst_n = r; instr_in = w; instr_valid = v; stall = s; flush = f; intr = it;
    @(posedge clk);
    cycle++;
    model_step(r, w, v, s, f, it);
    #1;
    check_model();
  endtask

  localparam logic [15:0] W_ADD  = 16'h4920;
  localparam logic [15:0] W_CALL = 16'hC060;
  localparam logic [15:0] W_LDM  = 16'h8840;
  localparam logic [15:0] W_RET  = 16'hD000;
  localparam logic [15:0] W_RTI  = 16'hE000;

  logic [4:0] int_ops [5] = '{5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111};

  initial begin
    logic [4:0]  rop;
    logic [15:0] rw;
    #1;
    // reset
    cyc(0, 16'h0, 0, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0, 0);
    chk("rst_op", {11'd0, opCode}, 16'h0000);
    chk("rst_bubble", {15'd0, makeMeBubble}, 16'h0001);
    chk("rst_pc_hold", {15'd0, pc_hold}, 16'h0000);
    chk("rst_imm", imm, 16'h0000);

    // ADD
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("add_op", {11'd0, opCode}, 16'h0009);
    chk("add_rsrc", {13'd0, rsrc}, 16'h0001);
    chk("add_rdst", {13'd0, rdst}, 16'h0001);

    // CALL rdst=3
    cyc(1, W_CALL, 1, 0, 0, 0);
    chk("call1_op", {11'd0, opCode}, 16'h0018);
    chk("call1_pc_hold", {15'd0, pc_hold}, 16'h0001);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("call2_op", {11'd0, opCode}, 16'h0019);
    chk("call2_rdst", {13'd0, rdst}, 16'h0003);

    // LDM rdst=2, stall, immediate
    cyc(1, W_LDM, 1, 0, 0, 0);
    chk("ldm_bubble", {15'd0, makeMeBubble}, 16'h0001);
    cyc(1, 16'hBEEF, 1, 1, 0, 0);
    chk("ldm_stall_pc_hold", {15'd0, pc_hold}, 16'h0001);
    cyc(1, 16'hBEEF, 1, 0, 0, 0);
    chk("ldm_op", {11'd0, opCode}, 16'h0011);
    chk("ldm_rdst", {13'd0, rdst}, 16'h0002);
    chk("ldm_imm", imm, 16'hBEEF);

    // intr during RET2, then RTI
    cyc(1, W_RET, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 0, 1);
    chk("ret2_op", {11'd0, opCode}, 16'h001B);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("int1_op", {11'd0, opCode}, 16'h001E);
    chk("int1_isr", {15'd0, in_isr}, 16'h0001);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("int2_op", {11'd0, opCode}, 16'h001F);
    chk("int2_pc_hold", {15'd0, pc_hold}, 16'h0001);
    cyc(1, W_ADD, 1, 0, 0, 0);
    cyc(1, W_RTI, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("rti2_op", {11'd0, opCode}, 16'h001D);
    chk("rti2_isr", {15'd0, in_isr}, 16'h0000);

    // simultaneous intr and stall: service deferred
    cyc(1, W_ADD, 1, 1, 0, 1);
    cyc(1, W_ADD, 1, 1, 0, 0);
    chk("stall_defer_op", {11'd0, opCode}, 16'h001D);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("stall_then_int1", {11'd0, opCode}, 16'h001E);
    cyc(1, W_ADD, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 0, 0);
    cyc(1, W_RTI, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 0, 0);

    // flush keeps pending
    cyc(1, W_ADD, 1, 0, 0, 1);
    cyc(1, W_ADD, 1, 0, 1, 0);
    chk("flush_bubble", {15'd0, makeMeBubble}, 16'h0001);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("flush_pending_int1", {11'd0, opCode}, 16'h001E);
    cyc(1, W_ADD, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 0, 0);

    // flush in CALL2
    cyc(1, W_CALL, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 1, 0);
    chk("flush_call2_op", {11'd0, opCode}, 16'h0000);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("after_flush_call2", {11'd0, opCode}, 16'h0009);

    // flush in INT1
    cyc(1, W_RTI, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 0, 1);
    cyc(1, W_ADD, 1, 0, 0, 0);
    cyc(1, W_ADD, 1, 0, 1, 0);
    chk("flush_int1_op", {11'd0, opCode}, 16'h001F);
    cyc(1, W_ADD, 1, 0, 0, 0);

    // reset in LDM_WAIT
    cyc(1, W_LDM, 1, 0, 0, 0);
    cyc(0, W_ADD, 1, 0, 0, 0);
    chk("rst_ldm_op", {11'd0, opCode}, 16'h0000);
    chk("rst_ldm_bubble", {15'd0, makeMeBubble}, 16'h0001);
    chk("rst_ldm_imm", imm, 16'h0000);
    chk("rst_ldm_isr", {15'd0, in_isr}, 16'h0000);
    cyc(1, W_ADD, 1, 0, 0, 0);
    chk("rst_ldm_abandon", {11'd0, opCode}, 16'h0009);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0:       rop = 5'b11000;
        1:       rop = 5'b11010;
        2:       rop = 5'b11100;
        3, 4:    rop = 5'b10001;
        5:       rop = int_ops[$urandom_range(0, 4)];
        default: rop = 5'($urandom_range(0, 31));
      endcase
      rw = {rop, 11'($urandom)};
      if ($urandom_range(0, 3) == 0) rw = 16'($urandom);
      cyc(($urandom_range(0, 99) != 0), rw, ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8),
          ($urandom_range(0, 99) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
